windowed_regfile: RTL
=====================

WINDOWED_REGFILE -- requirements
Module: windowed_regfile

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, register data width; ADDR_W, default 2, logical register index width, giving 2**ADDR_W registers per window; N_WIN, default 8, number of windows, minimum 2.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning), clock and reset first:
  clk  in  1  sole clock, rising-edge.
  rst  in  1  asynchronous active-low reset.
  in1  in  ADDR_W  read port 1 logical index.
  in2  in  ADDR_W  read port 2 logical index.
  wrR  in  ADDR_W  write logical index.
  data  in  DATA_W  write data.
  sig_write  in  1  write enable.
  win_inc  in  1  advance the window (call).
  win_dec  in  1  retreat the window (return).
  win_set  in  1  load the window pointer directly.
  win_sel  in  clog2(N_WIN)  target window for win_set.
  clr_flags  in  1  clear the sticky flags.
  out1  out  DATA_W  read port 1 data.
  out2  out  DATA_W  read port 2 data.
  cwp  out  clog2(N_WIN)  current window pointer.
  ovf  out  1  sticky window overflow flag.
  unf  out  1  sticky window underflow flag.

Function
REQ-003 Physical storage SHALL hold N_WIN*2**ADDR_W words; physical index = cwp*2**ADDR_W + logical index.
REQ-004 out1 and out2 SHALL be combinational reads through the current cwp.
REQ-005 On each rising clk edge with sig_write=1, data SHALL be written to physical (cwp, wrR) using the pre-edge cwp.
REQ-006 Bypass: when sig_write=1 and a read index equals wrR, that read output SHALL show data in the same cycle.
REQ-007 Window control priority SHALL be win_set > (win_inc xor win_dec); win_inc and win_dec both asserted without win_set SHALL leave cwp unchanged.
REQ-008 A win_set SHALL load cwp from win_sel on the edge; if win_sel >= N_WIN, cwp SHALL be unchanged and ovf SHALL be set.
REQ-009 A win_inc at cwp=N_WIN-1 SHALL leave cwp saturated and set ovf; otherwise cwp SHALL increment by 1.
REQ-010 A win_dec at cwp=0 SHALL leave cwp at 0 and set unf; otherwise cwp SHALL decrement by 1.
REQ-011 ovf and unf SHALL stay set until clr_flags is sampled at 1; a clear and a new set on the same edge SHALL leave the flag set.
REQ-012 A write and a window change on the same edge SHALL both occur; the write SHALL target the old window.
REQ-013 Reads SHALL use the new cwp starting the cycle after a window change.
REQ-014 Register contents SHALL persist across window changes (no spill or fill).

Reset
REQ-015 rst=0 SHALL asynchronously clear all storage, set cwp=0, and set ovf=0 and unf=0; with no write pending, out1 and out2 SHALL read 0.
REQ-016 Reset asserted mid-operation SHALL abort any pending write on that edge; the first write after release SHALL take effect on the first rising edge with rst=1.

Structure
REQ-017 The default widths, N_WIN, and a window-op encoding constant set SHALL live in a shared package, windowed_regfile_pkg.
REQ-018 A sub-module window_ptr SHALL own cwp, ovf and unf, and the saturation logic; the storage and bypass SHALL stay in the top module.

Verification
REQ-019 Reset release, write 29 to wrR=1 at cwp=0, read in1=1 -> out1=29 from the next cycle; in2=0 -> out2=0.
REQ-020 Same-cycle bypass: sig_write=1, wrR=2, data=0x00C4, in1=2 -> out1=0x00C4 before the edge.
REQ-021 Window isolation: write 7 to r1 at cwp=0, win_inc, write 9 to r1 -> cwp=1 and out1=9; win_dec -> out1=7.
REQ-022 Saturation: win_set with win_sel=7, then win_inc -> cwp=7 and ovf=1; clr_flags -> ovf=0; win_set win_sel=0, win_dec -> cwp=0 and unf=1.
REQ-023 Simultaneous events: win_inc plus win_dec -> cwp unchanged; write plus win_inc -> data lands in the old window.
REQ-024 Mid-operation reset: pulse rst=0 between edges with sig_write=1 -> all outputs 0 immediately and no write lands.

Source files
------------

// File: rtl/windowed_regfile_pkg.sv
// -----------------------------------------------------------------------------
// windowed_regfile_pkg
// Shared constants and types for the windowed register file:
//   - default data width, logical index width and window count
//   - window-operation encoding plus a decoder that applies the control
//     priority (set wins; inc and dec together cancel out)
// -----------------------------------------------------------------------------
package windowed_regfile_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 2;
    localparam int N_WIN_DEF  = 8;

    typedef enum logic [1:0] {
        WIN_HOLD = 2'd0,
        WIN_INC  = 2'd1,
        WIN_DEC  = 2'd2,
        WIN_SET  = 2'd3
    } win_op_e;

    function automatic win_op_e decode_win_op(input logic set,
                                              input logic inc,
                                              input logic dec);
        if (set)             return WIN_SET;
        else if (inc && !dec) return WIN_INC;
        else if (dec && !inc) return WIN_DEC;
        else                 return WIN_HOLD;
    endfunction

endpackage

// File: rtl/windowed_regfile_window_ptr.sv
// -----------------------------------------------------------------------------
// window_ptr
// Owns the current window pointer and the sticky overflow/underflow flags.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   win_inc_i      advance window (call); saturates at N_WIN-1 and flags ovf
//   win_dec_i      retreat window (return); saturates at 0 and flags unf
//   win_set_i      load pointer from win_sel_i (out-of-range sets ovf)
//   win_sel_i      target window for win_set_i
//   clr_flags_i    clear sticky flags (a same-edge set still wins)
//   cwp_o          current window pointer
//   ovf_o, unf_o   sticky overflow / underflow flags
// -----------------------------------------------------------------------------
module window_ptr
    import windowed_regfile_pkg::*;
#(
    parameter int N_WIN = N_WIN_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     win_inc_i,
    input  logic                     win_dec_i,
    input  logic                     win_set_i,
    input  logic [$clog2(N_WIN)-1:0] win_sel_i,
    input  logic                     clr_flags_i,
    output logic [$clog2(N_WIN)-1:0] cwp_o,
    output logic                     ovf_o,
    output logic                     unf_o
);

    localparam int                PTR_W    = $clog2(N_WIN);
    localparam logic [PTR_W-1:0]  LAST_WIN = PTR_W'(N_WIN - 1);
    // One extra bit so an out-of-range win_sel is detectable for any N_WIN.
    localparam logic [PTR_W:0]    N_WIN_L  = (PTR_W + 1)'(N_WIN);

    win_op_e          op;
    logic [PTR_W-1:0] cwp_q, cwp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             ovf_set, unf_set;

    assign op = decode_win_op(win_set_i, win_inc_i, win_dec_i);

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
        cwp_d   = cwp_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        case (op)
            WIN_SET: begin
                if ({1'b0, win_sel_i} >= N_WIN_L) ovf_set = 1'b1;
                else                              cwp_d   = win_sel_i;
            end
            WIN_INC: begin
                if (cwp_q == LAST_WIN) ovf_set = 1'b1;
                else                   cwp_d   = cwp_q + 1'b1;
            end
            WIN_DEC: begin
                if (cwp_q == '0) unf_set = 1'b1;
                else             cwp_d   = cwp_q - 1'b1;
            end
            default: ;
        endcase
        // A new event on the same edge as a clear keeps the flag set.
        ovf_d = ovf_set | (ovf_q & ~clr_flags_i);
        unf_d = unf_set | (unf_q & ~clr_flags_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cwp_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cwp_q <= cwp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign cwp_o = cwp_q;
    assign ovf_o = ovf_q;
    assign unf_o = unf_q;

endmodule

// File: rtl/windowed_regfile.sv
// -----------------------------------------------------------------------------
// windowed_regfile
// Register file split into N_WIN windows of 2**ADDR_W registers each. Reads
// and writes use logical indices relative to the current window pointer.
// Ports:
//   clk, rst            clock, asynchronous active-low reset (clears storage)
//   in1, in2            read port logical indices
//   out1, out2          combinational read data, with same-cycle write bypass
//   wrR, data           write logical index and data
//   sig_write           write enable (targets the pre-edge window)
//   win_inc, win_dec    call / return window moves
//   win_set, win_sel    direct window load
//   clr_flags           clear sticky ovf/unf
//   cwp, ovf, unf       window pointer and sticky flags
// -----------------------------------------------------------------------------
module windowed_regfile
    import windowed_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int N_WIN  = N_WIN_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        in1,
    input  logic [ADDR_W-1:0]        in2,
    input  logic [ADDR_W-1:0]        wrR,
    input  logic [DATA_W-1:0]        data,
    input  logic                     sig_write,
    input  logic                     win_inc,
    input  logic                     win_dec,
    input  logic                     win_set,
    input  logic [$clog2(N_WIN)-1:0] win_sel,
    input  logic                     clr_flags,
    output logic [DATA_W-1:0]        out1,
    output logic [DATA_W-1:0]        out2,
    output logic [$clog2(N_WIN)-1:0] cwp,
    output logic                     ovf,
    output logic                     unf
);

    localparam int PTR_W = $clog2(N_WIN);
    localparam int DEPTH = N_WIN << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_en;

    window_ptr #(.N_WIN(N_WIN)) u_window_ptr (
        .clk        (clk),
        .rst_n      (rst),
        .win_inc_i  (win_inc),
        .win_dec_i  (win_dec),
        .win_set_i  (win_set),
        .win_sel_i  (win_sel),
        .clr_flags_i(clr_flags),
        .cwp_o      (cwp),
        .ovf_o      (ovf),
        .unf_o      (unf)
    );

    // While reset is held no write is pending, so the bypass is gated too.
    assign wr_en = sig_write & rst;

    // {cwp, index} equals cwp*2**ADDR_W + index; the write uses the pre-edge cwp.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: storage must read 0 straight out of reset, so every word is cleared here, not just the control state.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[{cwp, wrR}] <= data;
        end
    end

    always_comb begin
        out1 = mem_q[{cwp, in1}];
        out2 = mem_q[{cwp, in2}];
        if (wr_en && (in1 == wrR)) out1 = data;
        if (wr_en && (in2 == wrR)) out2 = data;
    end

endmodule
